// File: rtl/tdm_demux.sv
// Time-division demultiplexer: gathers one WIDTH-bit word per slot into shadow registers
// and publishes a complete frame to q atomically, with frame_valid / frame_err pulses.
module tdm_demux #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned CHANNELS = 2,
  localparam int unsigned SLOT_W  = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          din,
  input  logic                      din_valid,
  input  logic                      sof,
  output logic [CHANNELS*WIDTH-1:0] q,
  output logic                      frame_valid,
  output logic                      frame_err,
  output logic [SLOT_W-1:0]         slot
);

  typedef enum logic [0:0] {StIdle, StCollect} state_e;

  localparam logic [SLOT_W-1:0] LastSlot = SLOT_W'(CHANNELS - 1);

  state_e                               state_q, state_d;
  logic   [SLOT_W-1:0]                  slot_q, slot_d;
  // The last slot is never shadowed: it goes straight from din into q.
  logic   [CHANNELS-2:0][WIDTH-1:0]     shadow_q, shadow_d;
  logic   [CHANNELS*WIDTH-1:0]          q_q, q_d;
  logic                                 fv_q, fv_d;
  logic                                 fe_q, fe_d;

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    shadow_d = shadow_q;
    q_d      = q_q;
    fv_d     = 1'b0;
    fe_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (din_valid && sof) begin
          shadow_d[0] = din;
          slot_d      = SLOT_W'(1);
          state_d     = StCollect;
        end
      end

      StCollect: begin
        if (din_valid) begin
          if (sof) begin
            // Early sof: abandon the partial frame and restart at slot 1.
            fe_d        = 1'b1;
            shadow_d[0] = din;
            slot_d      = SLOT_W'(1);
          end else if (slot_q == LastSlot) begin
            for (int k = 0; k < int'(CHANNELS) - 1; k++) begin
              q_d[k*WIDTH +: WIDTH] = shadow_q[k];
            end
            q_d[(CHANNELS-1)*WIDTH +: WIDTH] = din;
            fv_d    = 1'b1;
            slot_d  = '0;
            state_d = StIdle;
          end else begin
            for (int k = 0; k < int'(CHANNELS) - 1; k++) begin
              if (slot_q == SLOT_W'(k)) shadow_d[k] = din;
            end
            slot_d = slot_q + SLOT_W'(1);
          end
        end
      end

      default: begin
        state_d = StIdle;
        slot_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      slot_q   <= '0;
      shadow_q <= '0;
      q_q      <= '0;
      fv_q     <= 1'b0;
      fe_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      shadow_q <= shadow_d;
      q_q      <= q_d;
      fv_q     <= fv_d;
      fe_q     <= fe_d;
    end
  end

  assign q           = q_q;
  assign frame_valid = fv_q;
  assign frame_err   = fe_q;
  assign slot        = slot_q;

endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
Time-division demultiplexer: the receive-side counterpart of the team's 2:1 nibble mux. It takes a serial stream of WIDTH-bit words, one channel per slot, framed by a start-of-frame marker. It collects one word per channel into shadow registers. On frame completion it updates all parallel outputs atomically and pulses a strobe. It sits downstream of a mux-based serializer, rebuilding the per-channel buses d0, d1, ...

Parameters:
WIDTH, 4, bits per channel word
CHANNELS, 2, number of slots per frame; legal range 2..16
SLOT_W, $clog2(CHANNELS), width of the slot counter; derived, not overridden

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
din  input  WIDTH  serial word for the current slot
din_valid  input  1  din (and sof) valid this cycle
sof  input  1  start of frame; meaningful only when din_valid=1; marks din as slot 0
q  output  CHANNELS*WIDTH  demuxed words; channel k at q[k*WIDTH +: WIDTH]; registered
frame_valid  output  1  1-cycle pulse: q was updated with a complete frame this cycle
frame_err  output  1  1-cycle pulse: partial frame aborted by an early sof
slot  output  SLOT_W  current slot index expected next; debug/visibility

Behaviour:
- Reset (rst=1 at clk edge):
  - q=0, frame_valid=0, frame_err=0, slot=0, state=IDLE, shadow=0.
  - Reset wins over all other inputs.
  - Reset mid-frame discards the partial frame with no frame_err.
- States:
  - IDLE: waiting for sof.
  - COLLECT: slots 1..CHANNELS-1 pending.
- IDLE:
  - din_valid=1, sof=1 -> shadow[0]=din, slot=1, go COLLECT.
  - din_valid=1, sof=0 -> word dropped silently, stay IDLE.
  - din_valid=0 -> hold.
- COLLECT:
  - din_valid=0 -> hold all state; gaps of any length are allowed.
  - din_valid=1, sof=0, slot<CHANNELS-1 -> shadow[slot]=din, slot++.
  - din_valid=1, sof=0, slot==CHANNELS-1 (frame completion):
    - q <= {din, shadow[CHANNELS-2..0]}; all channels update in the same edge.
    - frame_valid=1 for exactly that following cycle.
    - slot=0, go IDLE.
  - din_valid=1, sof=1 (early sof, any slot):
    - frame_err=1 for one cycle; q unchanged.
    - Restart with shadow[0]=din, slot=1, stay COLLECT.
- Latency: the last word is sampled at edge N; q and frame_valid are visible after edge N, i.e. 1 clock.
- Back-to-back frames:
  - A sof on the cycle immediately after completion is accepted from IDLE.
  - Full-rate throughput is 1 word/cycle with no bubble required.
- q holds its last complete frame indefinitely; it never shows partial data.
- frame_valid and frame_err are never asserted in the same cycle.
- Outputs are pure registers; no combinational path from inputs to outputs.

Test Plan:
1. Reset, then valid words (sof=1,din=4'hA),(sof=0,din=4'h5) on consecutive cycles -> 1 cycle later q=8'h5A, frame_valid=1 for 1 cycle, slot=0.
2. Words with sof=0 while IDLE (din=4'h3 x3) -> ignored; q stays 0; no pulses; slot stays 0.
3. sof/din=4'h1, 3 idle cycles (din_valid=0), then din=4'h2 -> q=8'h21 one cycle after the 4'h2 word; frame_valid single pulse.
4. sof/4'h7, then sof/4'h8 (early sof), then 4'h9 -> frame_err pulse after 2nd word with q unchanged; then q=8'h98, frame_valid pulse.
5. rst asserted after sof/4'hC, then sof/4'h1, 4'h2 -> no frame_err; q=0 until final q=8'h21.
6. Continuous back-to-back frames (4'h1,4'h2),(4'h3,4'h4) with no gap -> q=8'h21 then 8'h43 on successive frame_valid pulses 2 cycles apart.
